rv_lsu: RTL and testbench
=========================

# rv_lsu

Load/store unit for the RV32I core: consumes the ALU result as the effective address for LOAD/STORE instructions, drives a request/grant/response memory port, and stalls the core until the access completes. Store data is byte-lane steered with byte enables. Load data is extracted, sign- or zero-extended, and returned on the writeback path. Sits directly downstream of the ALU, between the execute datapath and the data-memory interface.

## Interface
- `ADDR_WIDTH`, default 32: address width; must be 32.
- `DATA_WIDTH`, default 32: data width; must be 32 (RV32I).

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `lsu_req_i`  in  1  current instruction is a LOAD/STORE; held stable while `lsu_stall_o`=1
- `lsu_we_i`  in  1  1=store, 0=load
- `lsu_size_i`  in  2  0=byte, 1=half, 2=word, 3=reserved
- `lsu_unsigned_i`  in  1  zero-extend load (LBU/LHU)
- `lsu_addr_i`  in  ADDR_WIDTH  effective address (ALU result)
- `lsu_wdata_i`  in  DATA_WIDTH  store data (rs2)
- `lsu_stall_o`  out  1  hold PC/instruction (combinational)
- `lsu_misalign_o`  out  1  misaligned/reserved access, no memory op (combinational)
- `lsu_rdata_o`  out  DATA_WIDTH  extended load data
- `lsu_rdata_valid_o`  out  1  access complete this cycle
- `mem_req_o`  out  1  memory request
- `mem_gnt_i`  in  1  request accepted
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned address, bits [1:0]=0
- `mem_we_o`  out  1  write enable
- `mem_be_o`  out  4  byte enables
- `mem_wdata_o`  out  DATA_WIDTH  lane-steered write data
- `mem_rvalid_i`  in  1  response/write-ack valid
- `mem_rdata_i`  in  DATA_WIDTH  read data word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: if `lsu_req_i` & aligned, register the address, `we`, `size`, `unsigned`, steered wdata, and be. Go to REQ.
- IDLE: if `lsu_req_i` & misaligned, assert `lsu_misalign_o` and stay in IDLE. No memory request; no stall.
- REQ: `mem_req_o`=1 with address/we/be/wdata stable. On `mem_gnt_i`, go to RESP.
- RESP: `mem_req_o`=0. On `mem_rvalid_i`, register the extended load data (or leave `lsu_rdata_o` unchanged for stores). Go to DONE.
- DONE: `lsu_rdata_valid_o`=1 for exactly one cycle; `lsu_stall_o`=0 so the core retires. Go to IDLE.
- Stall: `lsu_stall_o` = `lsu_req_i` & aligned & state≠DONE. Forced to 0 while `reset`=1.
- Misalignment:
  - half with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - size 3, treated as misaligned
- Store steering:
  - byte: be=`4'b0001<<addr[1:0]`, wdata={4{wdata[7:0]}}
  - half: be=`4'b0011<<addr[1:0]`, wdata={2{wdata[15:0]}}
  - word: be=`4'hF`, wdata unchanged
- Loads drive be per the same rule. `mem_addr_o`={addr[31:2],2'b00}.
- Load extraction:
  - byte: `mem_rdata_i >> (8*addr[1:0])`, bits [7:0]
  - half: `mem_rdata_i >> (16*addr[1])`, bits [15:0]
  - Sign-extend from the MSB unless `unsigned`. Word passes through.
- `mem_rvalid_i` outside RESP is ignored. `mem_gnt_i` outside REQ is ignored.

## Timing
- Reset values: state=IDLE; `mem_req_o`, `mem_we_o`, `lsu_rdata_valid_o` = 0; `mem_be_o`=0; `mem_addr_o`, `mem_wdata_o`, `lsu_rdata_o` = 0.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first RESP cycle: accept in cycle 0, `mem_req_o` in cycle 1, rvalid in cycle 2, `lsu_rdata_valid_o` in cycle 3. Stall is high in cycles 0–2.
- `mem_rvalid_i` must arrive no earlier than the cycle after `mem_gnt_i`. Unbounded gnt/rvalid wait states are allowed; the FSM holds.
- Only one outstanding request at a time.
- Back-to-back accesses: a new request is accepted in the IDLE cycle following DONE.
- Reset mid-operation, in any state: next cycle is IDLE with all outputs at reset values. A late `mem_rvalid_i` is ignored.
- Request inputs are sampled only in IDLE; changes during REQ/RESP/DONE have no effect.

## Test plan
- LW addr 0x100, gnt in 1st REQ cycle, rvalid with rdata 0xDEADBEEF in 1st RESP cycle → mem_addr 0x100, be 0xF; rdata_valid in cycle 3, rdata 0xDEADBEEF; stall high in cycles 0–2.
- LB addr 0x103, rdata 0x80FF_0000 → be 0x8, rdata 0xFFFFFF80. LBU at the same address → 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x21, wdata 0x123456AB → mem_addr 0x20, be 0x2, mem_wdata 0xABABABAB, we=1. Completes on the rvalid ack.
- LH addr 0x101, then LW addr 0x102 → misalign=1, stall=0, `mem_req_o` never asserted.
- gnt delayed 3 cycles, rvalid delayed 2 → `mem_req_o` and address held 4 cycles, stall held throughout, rdata_valid exactly 1 cycle.
- Reset asserted in RESP, then rvalid arrives → state IDLE, rdata_valid stays 0, `mem_req_o` 0, outputs at reset values.

Source files
------------

// File: rtl/rv_lsu.sv
// RV32I load/store unit: one outstanding access on a req/gnt/rvalid data port.
// Steers store bytes, extends load data and stalls the core until the access retires.
module rv_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_stall_o,
    output logic                  lsu_misalign_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_rdata_valid_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            off_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  misaligned;
    logic                  accept;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ext;

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'hF;
        wdata_d    = lsu_wdata_i;
        case (lsu_size_i)
            2'd0: begin
                be_d    = 4'b0001 << lsu_addr_i[1:0];
                wdata_d = {4{lsu_wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = lsu_addr_i[0];
                be_d       = 4'b0011 << lsu_addr_i[1:0];
                wdata_d    = {2{lsu_wdata_i[15:0]}};
            end
            2'd2:    misaligned = |lsu_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign accept = lsu_req_i & ~misaligned;

    // Extraction uses the offset captured at accept; core inputs may change after IDLE.
    always_comb begin
        shifted = '0;
        ext     = mem_rdata_i;
        case (size_q)
            2'd0: begin
                shifted = mem_rdata_i >> {off_q, 3'b000};
                ext     = {{(DATA_WIDTH-8){~uns_q & shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                shifted = mem_rdata_i >> {off_q[1], 4'b0000};
                ext     = {{(DATA_WIDTH-16){~uns_q & shifted[15]}}, shifted[15:0]};
            end
            default: ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)       state_d = REQ;
            REQ:     if (mem_gnt_i)    state_d = RESP;
            RESP:    if (mem_rvalid_i) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            be_q    <= 4'h0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && accept) begin
                addr_q  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                we_q    <= lsu_we_i;
                size_q  <= lsu_size_i;
                uns_q   <= lsu_unsigned_i;
                off_q   <= lsu_addr_i[1:0];
                be_q    <= be_d;
                wdata_q <= wdata_d;
            end
            if (state_q == RESP && mem_rvalid_i && !we_q)
                rdata_q <= ext;
        end
    end

    assign mem_req_o         = (state_q == REQ);
    assign mem_addr_o        = addr_q;
    assign mem_we_o          = we_q;
    assign mem_be_o          = be_q;
    assign mem_wdata_o       = wdata_q;
    assign lsu_rdata_o       = rdata_q;
    assign lsu_rdata_valid_o = (state_q == DONE);
    assign lsu_stall_o       = ~reset & accept & (state_q != DONE);
    assign lsu_misalign_o    = ~reset & lsu_req_i & misaligned & (state_q == IDLE);

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_rv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_stall_o, lsu_misalign_o, lsu_rdata_valid_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    int checks = 0;
    int errors = 0;

    rv_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
        .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_misalign_o(lsu_misalign_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_rdata_valid_o(lsu_rdata_valid_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One aligned access; called just after a falling edge, returns just after the
    // falling edge that follows the DONE cycle.
    task automatic acc(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input int gw, input int rw, input logic [31:0] rd,
                       input logic [31:0] e_addr, input logic [3:0] e_be,
                       input logic [31:0] e_wd, input logic [31:0] e_rd);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_unsigned_i = uns;
        lsu_addr_i = addr; lsu_wdata_i = wd;
        #1;
        chk({tag, ".c0_stall"}, 32'(lsu_stall_o), 32'd1);
        chk({tag, ".c0_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, ".c0_mis"}, 32'(lsu_misalign_o), 32'd0);
        @(negedge clk);
        for (int k = 0; k <= gw; k++) begin
            mem_gnt_i = (k == gw);
            #1;
            chk({tag, ".req"}, 32'(mem_req_o), 32'd1);
            chk({tag, ".stall_req"}, 32'(lsu_stall_o), 32'd1);
            chk({tag, ".addr"}, mem_addr_o, e_addr);
            chk({tag, ".be"}, 32'(mem_be_o), 32'(e_be));
            chk({tag, ".we"}, 32'(mem_we_o), 32'(we));
            chk({tag, ".wdata"}, mem_wdata_o, e_wd);
            @(negedge clk);
        end
        mem_gnt_i = 1'b0;
        for (int k = 0; k <= rw; k++) begin
            mem_rvalid_i = (k == rw);
            mem_rdata_i  = (k == rw) ? rd : 32'h0BAD_0BAD;
            #1;
            chk({tag, ".resp_req"}, 32'(mem_req_o), 32'd0);
            chk({tag, ".stall_resp"}, 32'(lsu_stall_o), 32'd1);
            chk({tag, ".resp_vld"}, 32'(lsu_rdata_valid_o), 32'd0);
            @(negedge clk);
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        #1;
        chk({tag, ".done_vld"}, 32'(lsu_rdata_valid_o), 32'd1);
        chk({tag, ".done_stall"}, 32'(lsu_stall_o), 32'd0);
        chk({tag, ".rdata"}, lsu_rdata_o, e_rd);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'd0;
        lsu_unsigned_i = 1'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst.req", 32'(mem_req_o), 32'd0);
        chk("rst.vld", 32'(lsu_rdata_valid_o), 32'd0);
        chk("rst.addr", mem_addr_o, 32'h0);
        chk("rst.be", 32'(mem_be_o), 32'h0);
        chk("rst.rdata", lsu_rdata_o, 32'h0);
        lsu_req_i = 1'b1; lsu_size_i = 2'd2; lsu_addr_i = 32'h100;
        #1;
        chk("rst.stall_forced", 32'(lsu_stall_o), 32'd0);
        lsu_req_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Loads, back to back: each starts in the IDLE cycle right after the previous DONE
        acc("lw",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
            32'h100, 4'hF, 32'h0, 32'hDEADBEEF);
        acc("lb",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000,
            32'h100, 4'h8, 32'h0, 32'hFFFFFF80);
        acc("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 0, 32'h80FF_0000,
            32'h100, 4'h8, 32'h0, 32'h00000080);
        acc("lh",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, 0, 32'h80FF_0000,
            32'h100, 4'hC, 32'h0, 32'hFFFF80FF);
        acc("lhu", 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 0, 0, 32'h80FF_0000,
            32'h100, 4'hC, 32'h0, 32'h000080FF);
        acc("lb1", 1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 0, 0, 32'h1122_3344,
            32'h200, 4'h2, 32'h0, 32'h00000033);

        // Stores leave the load result register untouched
        acc("sb", 1'b1, 2'd0, 1'b0, 32'h21, 32'h123456AB, 0, 0, 32'h5555_5555,
            32'h20, 4'h2, 32'hABABABAB, 32'h00000033);
        acc("sh", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 0, 1, 32'h5555_5555,
            32'h20, 4'hC, 32'hBEEFBEEF, 32'h00000033);
        acc("sw", 1'b1, 2'd2, 1'b0, 32'h44, 32'h12345678, 1, 0, 32'h5555_5555,
            32'h44, 4'hF, 32'h12345678, 32'h00000033);

        // Wait states: gnt after 3 extra REQ cycles, rvalid after 2 extra RESP cycles
        acc("lw_wait", 1'b0, 2'd2, 1'b0, 32'h3C0, 32'h0, 3, 2, 32'hCAFEF00D,
            32'h3C0, 4'hF, 32'h0, 32'hCAFEF00D);
        lsu_req_i = 1'b0;
        #1;
        chk("post.vld", 32'(lsu_rdata_valid_o), 32'd0);
        chk("post.req", 32'(mem_req_o), 32'd0);
        @(negedge clk);

        // Misaligned / reserved accesses: flagged, never stalled, never sent to memory
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_unsigned_i = 1'b0;
        lsu_size_i = 2'd1; lsu_addr_i = 32'h101;
        #1;
        chk("mis_lh.flag", 32'(lsu_misalign_o), 32'd1);
        chk("mis_lh.stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk);
        lsu_size_i = 2'd2; lsu_addr_i = 32'h102;
        #1;
        chk("mis_lh.req", 32'(mem_req_o), 32'd0);
        chk("mis_lw.flag", 32'(lsu_misalign_o), 32'd1);
        chk("mis_lw.stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk);
        lsu_size_i = 2'd3; lsu_addr_i = 32'h100;
        #1;
        chk("mis_lw.req", 32'(mem_req_o), 32'd0);
        chk("mis_rsv.flag", 32'(lsu_misalign_o), 32'd1);
        chk("mis_rsv.stall", 32'(lsu_stall_o), 32'd0);
        @(negedge clk);
        lsu_req_i = 1'b0;
        #1;
        chk("mis_rsv.req", 32'(mem_req_o), 32'd0);
        chk("mis.addr_kept", mem_addr_o, 32'h3C0);
        @(negedge clk);

        // Reset while waiting in RESP; the late rvalid must be dropped
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 2'd2; lsu_addr_i = 32'h80;
        lsu_wdata_i = 32'hA5A5A5A5;
        @(negedge clk);
        mem_gnt_i = 1'b1;
        #1;
        chk("rr.req", 32'(mem_req_o), 32'd1);
        @(negedge clk);
        mem_gnt_i = 1'b0;
        reset = 1'b1;
        #1;
        chk("rr.stall_forced", 32'(lsu_stall_o), 32'd0);
        @(negedge clk);
        reset = 1'b0; lsu_req_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        #1;
        chk("rr.vld", 32'(lsu_rdata_valid_o), 32'd0);
        chk("rr.req0", 32'(mem_req_o), 32'd0);
        chk("rr.addr", mem_addr_o, 32'h0);
        chk("rr.we", 32'(mem_we_o), 32'd0);
        chk("rr.be", 32'(mem_be_o), 32'h0);
        chk("rr.wdata", mem_wdata_o, 32'h0);
        chk("rr.rdata", lsu_rdata_o, 32'h0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        chk("rr.vld_late", 32'(lsu_rdata_valid_o), 32'd0);
        chk("rr.rdata_late", lsu_rdata_o, 32'h0);
        chk("rr.req_late", 32'(mem_req_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
